calc_port_arbiter: RTL

CALC_PORT_ARBITER -- requirements
Module: calc_port_arbiter

---
 rtl/calc_port_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_port_arbiter.sv
// -----------------------------------------------------------------------------
// calc_port_arbiter
//
// Shares one two-beat calculator port between four requesters. One requester
// is granted at a time, picked round-robin. Its command and both operands are
// sent to the calculator on consecutive cycles. The block then waits a bounded
// number of cycles for a response and returns it to that requester as a
// single-cycle strobe.
//
// Ports (requester N owns slice N of each packed vector):
//   c_clk          in   1    clock, all flops on the rising edge
//   reset_n        in   1    asynchronous active-low reset
//   req_valid      in   4    pending command per requester
//   req_cmd        in   16   4-bit command per requester
//   req_op1        in   128  32-bit first operand per requester
//   req_op2        in   128  32-bit second operand per requester
//   req_ready      out  4    one-cycle accept strobe
//   rsp_valid      out  4    one-cycle result strobe
//   rsp_resp       out  8    2-bit response per requester (0 when not strobed)
//   rsp_data       out  128  32-bit result per requester (0 when not strobed)
//   calc_cmd       out  4    command to the calculator
//   calc_data      out  32   operand to the calculator
//   calc_resp      in   2    calculator response, 0 = none (only seen in WAIT)
//   calc_out_data  in   32   calculator result
//   busy           out  1    high whenever the FSM is not in IDLE
//
// State    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no transaction; grant the next valid requester round-robin
// SEND1    | calc_cmd = cmd, calc_data = op1
// SEND2    | calc_cmd = 0,   calc_data = op2
// WAIT     | wait for calc_resp != 0, bounded by TIMEOUT cycles
// RESP     | rsp_valid/rsp_resp/rsp_data strobed to the granted requester
// -----------------------------------------------------------------------------
module calc_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic         c_clk,
  input  logic         reset_n,
  input  logic [3:0]   req_valid,
  input  logic [15:0]  req_cmd,
  input  logic [127:0] req_op1,
  input  logic [127:0] req_op2,
  output logic [3:0]   req_ready,
  output logic [3:0]   rsp_valid,
  output logic [7:0]   rsp_resp,
  output logic [127:0] rsp_data,
  output logic [3:0]   calc_cmd,
  output logic [31:0]  calc_data,
  input  logic [1:0]   calc_resp,
  input  logic [31:0]  calc_out_data,
  output logic         busy
);

  // The wait counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] RESP_BADCMD  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND1 = 3'd1,
    S_SEND2 = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t         state_q;
  logic [1:0]     last_grant_q;
  logic [1:0]     gnt_q;
  logic [31:0]    op2_q;
  logic [CW-1:0]  wait_cnt_q;
  logic [3:0]     calc_cmd_q;
  logic [31:0]    calc_data_q;
  logic [3:0]     rsp_valid_q;
  logic [7:0]     rsp_resp_q;
  logic [127:0]   rsp_data_q;

  // Round-robin pick: the search starts one past the last grant. The index
  // math wraps in two bits, so the fourth candidate is the last grant itself.
  logic        grant_found_d;
  logic [1:0]  grant_idx_d;
  logic [1:0]  cand;

  always_comb begin
    grant_found_d = 1'b0;
    grant_idx_d   = last_grant_q;
    cand          = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!grant_found_d && req_valid[cand]) begin
        grant_found_d = 1'b1;
        grant_idx_d   = cand;
      end
    end
  end

  logic [3:0]  grant_cmd_d;
  logic [31:0] grant_op1_d;
  logic [31:0] grant_op2_d;
  logic        cmd_ok_d;

  assign grant_cmd_d = req_cmd[{grant_idx_d, 2'b00} +: 4];
  assign grant_op1_d = req_op1[{grant_idx_d, 5'd0} +: 32];
  assign grant_op2_d = req_op2[{grant_idx_d, 5'd0} +: 32];

  always_comb begin
    cmd_ok_d = 1'b0;
    case (grant_cmd_d)
      4'd1, 4'd2, 4'd5, 4'd6: cmd_ok_d = 1'b1;
      default:                cmd_ok_d = 1'b0;
    endcase
  end

  // The accept strobe has to appear in the cycle the grant is decided, so
  // it is decoded from the registered state. It is gated with reset_n so that
  // it stays low while reset is held, even if requests are present.
  always_comb begin
    req_ready = 4'b0000;
    if (reset_n && (state_q == S_IDLE) && grant_found_d) begin
      req_ready = 4'b0001 << grant_idx_d;
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 2'd3;
      gnt_q        <= 2'd0;
      op2_q        <= '0;
      wait_cnt_q   <= '0;
      calc_cmd_q   <= '0;
      calc_data_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_resp_q   <= '0;
      rsp_data_q   <= '0;
    end else begin
      // Response outputs are single-cycle; they are only set on entry to RESP.
      rsp_valid_q <= '0;
      rsp_resp_q  <= '0;
      rsp_data_q  <= '0;

      case (state_q)
        S_IDLE: begin
          if (grant_found_d) begin
            last_grant_q <= grant_idx_d;
            gnt_q        <= grant_idx_d;
            if (cmd_ok_d) begin
              state_q     <= S_SEND1;
              calc_cmd_q  <= grant_cmd_d;
              calc_data_q <= grant_op1_d;
              op2_q       <= grant_op2_d;
            end else begin
              // Unsupported command: answer at once, calculator untouched.
              state_q                             <= S_RESP;
              rsp_valid_q[grant_idx_d]            <= 1'b1;
              rsp_resp_q[{grant_idx_d, 1'b0} +: 2] <= RESP_BADCMD;
            end
          end
        end

        S_SEND1: begin
          state_q     <= S_SEND2;
          calc_cmd_q  <= '0;
          calc_data_q <= op2_q;
        end

        S_SEND2: begin
          state_q     <= S_WAIT;
          calc_data_q <= '0;
          wait_cnt_q  <= '0;
        end

        S_WAIT: begin
          // A real response wins over the timeout in the final cycle.
          if (calc_resp != 2'b00) begin
            state_q                            <= S_RESP;
            rsp_valid_q[gnt_q]                 <= 1'b1;
            rsp_resp_q[{gnt_q, 1'b0} +: 2]     <= calc_resp;
            rsp_data_q[{gnt_q, 5'd0} +: 32]    <= calc_out_data;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q                            <= S_RESP;
            rsp_valid_q[gnt_q]                 <= 1'b1;
            rsp_resp_q[{gnt_q, 1'b0} +: 2]     <= RESP_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_data  = rsp_data_q;
  assign calc_cmd  = calc_cmd_q;
  assign calc_data = calc_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule
